roachf_1024_bao_eq_coeff_loader: RTL and testbench
==================================================

// Module: roachf_1024_bao_eq_coeff_loader
// PURPOSE
//  Consumes the software-written EQ quantiser address, data and control registers (user_clk domain outputs of
//  the OPB register bridges) and turns them into single-cycle write strobes on the EQ coefficient BRAM port.
//  Supports single writes, auto-increment burst writes and a hardware clear sweep.
//  Sits between the EQ_quant2 addr/data/ctrl registers and the quantiser coefficient RAM.
// PARAMETERS
//  ADDR_W         10       coefficient RAM address width (RAM depth = 2**ADDR_W channels)
//  COEFF_W        16       coefficient width; taken from data_reg[COEFF_W-1:0]
//  DEFAULT_COEFF  16'h1000 value written to every address by a clear sweep
// PORTS
//  user_clk    in   1        sole clock
//  user_rst_n  in   1        asynchronous active-low reset
//  addr_reg    in   32       target address from the EQ_quant2 addr register
//  data_reg    in   32       coefficient value from the data register
//  ctrl_reg    in   32       [0] write trigger, [1] autoinc mode, [2] load pointer, [3] clear; others ignored
//  coeff_we    out  1        RAM write enable, one cycle per write
//  coeff_addr  out  ADDR_W   RAM write address
//  coeff_din   out  COEFF_W  RAM write data
//  busy        out  1        high while a clear sweep is running
//  write_count out  16       completed writes, wraps at 2**16
//  err_count   out  16       dropped requests, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, ptr=0, all input registers 0.
//  - Input stage: addr/data/ctrl registered once (_q); ctrl_q registered again (ctrl_q2).
//    A rising edge on bit b is ctrl_q[b] & ~ctrl_q2[b].
//  - Startup guard: no edges are honoured on the first 2 clock edges after user_rst_n deasserts.
//    A ctrl bit held high through reset therefore never triggers.
//  - Pointer load: in IDLE, a rising edge on bit2 sets ptr = addr_q[ADDR_W-1:0]; no write results.
//  - FSM states: IDLE, CLEAR. Single writes complete within IDLE.
//  - IDLE, rising edge on bit0:
//    - target = ctrl_q[1] ? ptr : addr_q[ADDR_W-1:0].
//    - If ctrl_q[1]=0 and addr_q[31:ADDR_W] != 0: no write; err_count++.
//    - Otherwise, on the next edge: coeff_we=1, coeff_addr=target, coeff_din=data_q[COEFF_W-1:0], write_count++.
//    - If ctrl_q[1]=1: ptr increments mod 2**ADDR_W on that same edge.
//    - Latency: ctrl_reg[0] first sampled high at edge E0 -> coeff_we high for the one cycle after E2.
//  - Same-cycle events in IDLE:
//    - bit0 and bit2 edges together: the load applies first, then the write uses the new ptr.
//    - bit3 edge with or without bit0: CLEAR wins; a coincident bit0 edge is dropped and err_count++.
//  - IDLE, rising edge on bit3: go to CLEAR.
//    - Next edge: busy=1, coeff_we=1, coeff_addr=0, coeff_din=DEFAULT_COEFF.
//    - coeff_addr increments by 1 each cycle.
//    - The cycle addressing 2**ADDR_W-1 is the last. On the following edge: coeff_we=0, busy=0, state=IDLE.
//    - Sweep = exactly 2**ADDR_W consecutive write cycles; write_count += 2**ADDR_W (wrapping).
//    - ptr is reset to 0 at sweep end.
//  - In CLEAR: bit0 rising edges are dropped with err_count++. Bit2 and bit3 edges are ignored, not counted.
//  - coeff_we is low in every cycle not listed above. coeff_addr/coeff_din hold their last values while we=0.
//  - Reset asserted mid-sweep: immediate return to reset values. The sweep is not resumed after reset.
//  - err_count saturates at 16'hFFFF; write_count wraps 16'hFFFF -> 0.
// TESTING
//  1. addr=5, data=0x0ABC, pulse ctrl=0x1 -> one we cycle, addr=5, din=0x0ABC, 2 cycles after sampling; write_count=1.
//  2. addr=1022, ctrl=0x4 then 0x0; then data=0x11 with ctrl=0x3, ctrl=0x2 repeated 3 times
//     -> writes to 1022, 1023, 0; ptr ends at 1.
//  3. ctrl=0x8 pulse -> busy high 1024 cycles; 1024 contiguous we cycles, addr 0..1023, din=0x1000; then idle.
//  4. addr=0x400 (bit 10 set), ctrl=0x1 -> no we; err_count=1.
//     Bit0 pulse during a sweep -> err_count=2; the sweep is undisturbed.
//  5. Bit0 and bit3 rising together -> clear sweep only; err_count=1.
//  6. Reset at sweep address 300 with ctrl_reg=0x1 held high through release
//     -> all outputs 0; no write and no sweep after release.

Source files
------------

// File: rtl/roachf_1024_bao_eq_coeff_loader.sv
// EQ coefficient loader: turns software addr/data/ctrl registers into
// single-cycle coefficient RAM writes, auto-increment bursts and clear sweeps.
module roachf_1024_bao_eq_coeff_loader #(
  parameter int ADDR_W = 10,
  parameter int COEFF_W = 16,
  parameter logic [COEFF_W-1:0] DEFAULT_COEFF = 16'h1000
) (
  input  logic               user_clk,
  input  logic               user_rst_n,
  input  logic [31:0]        addr_reg,
  input  logic [31:0]        data_reg,
  input  logic [31:0]        ctrl_reg,
  output logic               coeff_we,
  output logic [ADDR_W-1:0]  coeff_addr,
  output logic [COEFF_W-1:0] coeff_din,
  output logic               busy,
  output logic [15:0]        write_count,
  output logic [15:0]        err_count
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e state_q, state_d;

  logic [31:0]        addr_q;
  logic [COEFF_W-1:0] data_q;
  logic [3:0]         ctrl_q;
  logic [3:0]         ctrl_q2;
  logic [1:0]         guard_q, guard_d;
  logic [3:0]         rise, rise_q;
  logic               guard_ok;

  logic [ADDR_W-1:0]  ptr_q, ptr_d, ptr_new;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  caddr_q, caddr_d;
  logic [COEFF_W-1:0] din_q, din_d;
  logic               busy_q, busy_d;
  logic [15:0]        wc_q, wc_d;
  logic [15:0]        err_q, err_d;
  logic               err_inc;
  logic               addr_bad;

  logic unused_ok;
  assign unused_ok = ^{ctrl_reg[31:4], data_reg[31:COEFF_W],
                       rise_q[1]};

  // Edges are masked until two clocks after reset release.
  assign guard_ok = (guard_q == 2'd2);
  assign guard_d  = guard_ok ? guard_q : guard_q + 2'd1;
  assign rise     = ctrl_q & ~ctrl_q2 & {4{guard_ok}};
  assign addr_bad = (addr_q[31:ADDR_W] != '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ptr_new = ptr_q;
    we_d    = 1'b0;
    caddr_d = caddr_q;
    din_d   = din_q;
    busy_d  = busy_q;
    err_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise_q[3]) begin
          state_d = CLEAR;
          err_inc = rise_q[0];
        end else begin
          if (rise_q[2]) ptr_new = addr_q[ADDR_W-1:0];
          ptr_d = ptr_new;
          if (rise_q[0]) begin
            if (!ctrl_q[1] && addr_bad) begin
              err_inc = 1'b1;
            end else begin
              we_d    = 1'b1;
              caddr_d = ctrl_q[1] ? ptr_new : addr_q[ADDR_W-1:0];
              din_d   = data_q;
              if (ctrl_q[1]) ptr_d = ptr_new + 1'b1;
            end
          end
        end
      end
      CLEAR: begin
        err_inc = rise_q[0];
        if (!busy_q) begin
          busy_d  = 1'b1;
          we_d    = 1'b1;
          caddr_d = '0;
          din_d   = DEFAULT_COEFF;
        end else if (caddr_q == '1) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          we_d    = 1'b1;
          caddr_d = caddr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    wc_d  = wc_q + {15'd0, we_d};
    err_d = (err_inc && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
      ctrl_q2 <= '0;
      guard_q <= '0;
      rise_q  <= '0;
      state_q <= IDLE;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      caddr_q <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      wc_q    <= '0;
      err_q   <= '0;
    end else begin
      addr_q  <= addr_reg;
      data_q  <= data_reg[COEFF_W-1:0];
      ctrl_q  <= ctrl_reg[3:0];
      ctrl_q2 <= ctrl_q;
      guard_q <= guard_d;
      rise_q  <= rise;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      caddr_q <= caddr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      wc_q    <= wc_d;
      err_q   <= err_d;
    end
  end

  assign coeff_we    = we_q;
  assign coeff_addr  = caddr_q;
  assign coeff_din   = din_q;
  assign busy        = busy_q;
  assign write_count = wc_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_roachf_1024_bao_eq_coeff_loader.sv
// Directed bench for the EQ coefficient loader.
// Writes, bursts, clear sweeps, error drops and mid-sweep reset.
module tb_roachf_1024_bao_eq_coeff_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr_reg, data_reg, ctrl_reg;
  logic        coeff_we;
  logic [9:0]  coeff_addr;
  logic [15:0] coeff_din;
  logic        busy;
  logic [15:0] write_count, err_count;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy_n = 0;
  logic [9:0]  la[$];
  logic [15:0] ld[$];
  int          lc[$];

  roachf_1024_bao_eq_coeff_loader dut (
    .user_clk(clk), .user_rst_n(rst_n),
    .addr_reg(addr_reg), .data_reg(data_reg), .ctrl_reg(ctrl_reg),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_din(coeff_din),
    .busy(busy), .write_count(write_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (coeff_we) begin
      la.push_back(coeff_addr);
      ld.push_back(coeff_din);
      lc.push_back(cyc);
    end
    if (busy) busy_n = busy_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    la.delete();
    ld.delete();
    lc.delete();
    busy_n = 0;
  endtask

  task automatic set_ctrl(input logic [31:0] v, input int n);
    ctrl_reg = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_sweep(input string tag);
    int bad = 0;
    chk({tag, "_len"}, la.size(), 1024);
    if (la.size() == 1024) begin
      for (int i = 0; i < 1024; i++) begin
        if (la[i] != i[9:0]) bad++;
        if (ld[i] != 16'h1000) bad++;
        if (lc[i] != lc[0] + i) bad++;
      end
    end
    chk({tag, "_content"}, bad, 0);
    chk({tag, "_busy_cycles"}, busy_n, 1024);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    int e0;
    bit hit;
    rst_n = 1'b0;
    addr_reg = '0;
    data_reg = '0;
    ctrl_reg = '0;
    repeat (3) @(negedge clk);
    chk("rst_we", coeff_we, 0);
    chk("rst_addr", coeff_addr, 0);
    chk("rst_din", coeff_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wc", write_count, 0);
    chk("rst_err", err_count, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // single write with latency check
    clr_log();
    addr_reg = 32'd5;
    data_reg = 32'h0ABC;
    e0 = cyc + 1;
    set_ctrl(32'h1, 3);
    set_ctrl(32'h0, 5);
    chk("t1_len", la.size(), 1);
    if (la.size() == 1) begin
      chk("t1_addr", la[0], 5);
      chk("t1_din", ld[0], 16'h0ABC);
      chk("t1_lat", lc[0], e0 + 2);
    end
    chk("t1_wc", write_count, 1);

    // pointer load then autoinc burst across the wrap
    clr_log();
    addr_reg = 32'd1022;
    set_ctrl(32'h4, 3);
    set_ctrl(32'h0, 3);
    chk("t2_load_no_we", la.size(), 0);
    data_reg = 32'h11;
    for (int k = 0; k < 3; k++) begin
      set_ctrl(32'h3, 3);
      set_ctrl(32'h2, 3);
    end
    set_ctrl(32'h3, 3);
    set_ctrl(32'h0, 5);
    chk("t2_len", la.size(), 4);
    if (la.size() == 4) begin
      chk("t2_a0", la[0], 1022);
      chk("t2_a1", la[1], 1023);
      chk("t2_a2", la[2], 0);
      chk("t2_ptr_end", la[3], 1);
      chk("t2_din", ld[2], 16'h11);
    end
    chk("t2_wc", write_count, 5);

    // clear sweep
    clr_log();
    set_ctrl(32'h8, 3);
    set_ctrl(32'h0, 1040);
    chk_sweep("t3");
    chk("t3_wc", write_count, 5 + 1024);
    clr_log();
    data_reg = 32'h22;
    set_ctrl(32'h3, 3);
    set_ctrl(32'h0, 5);
    chk("t3_ptr_len", la.size(), 1);
    if (la.size() == 1) chk("t3_ptr_zero", la[0], 0);
    chk("t3_wc2", write_count, 1030);

    // out of range address and bit0 during a sweep
    clr_log();
    addr_reg = 32'h400;
    set_ctrl(32'h1, 3);
    set_ctrl(32'h0, 5);
    chk("t4_no_we", la.size(), 0);
    chk("t4_err1", err_count, 1);
    chk("t4_wc", write_count, 1030);
    clr_log();
    addr_reg = 32'd7;
    set_ctrl(32'h8, 3);
    set_ctrl(32'h0, 100);
    set_ctrl(32'h1, 3);
    set_ctrl(32'h0, 1000);
    chk_sweep("t4");
    chk("t4_err2", err_count, 2);
    chk("t4_wc2", write_count, 1030 + 1024);

    // bit0 and bit3 together
    do_reset();
    clr_log();
    addr_reg = 32'd9;
    set_ctrl(32'h9, 3);
    set_ctrl(32'h0, 1040);
    chk_sweep("t5");
    chk("t5_err", err_count, 1);
    chk("t5_wc", write_count, 1024);

    // reset mid-sweep with ctrl bit0 held through release
    clr_log();
    set_ctrl(32'h8, 3);
    set_ctrl(32'h0, 1);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (coeff_we && coeff_addr == 10'd300) hit = 1'b1;
    end
    chk("t6_reach300", hit, 1);
    rst_n = 1'b0;
    ctrl_reg = 32'h1;
    #1;
    chk("t6_we", coeff_we, 0);
    chk("t6_addr", coeff_addr, 0);
    chk("t6_busy", busy, 0);
    chk("t6_wc", write_count, 0);
    repeat (3) @(negedge clk);
    clr_log();
    rst_n = 1'b1;
    repeat (1100) @(posedge clk);
    #1;
    chk("t6_no_we", la.size(), 0);
    chk("t6_no_busy", busy_n, 0);
    chk("t6_wc_after", write_count, 0);
    chk("t6_err_after", err_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
